// File: rtl/sum_capture_pkg.sv
// Shared definitions for the sum_capture block: FSM state encodings and
// the width of the event counters.
package sum_capture_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/capture_fifo.sv
// First-word-fall-through capture FIFO. The head entry is presented
// combinationally whenever the FIFO is non-empty. A push into an empty FIFO
// becomes visible one cycle later; there is no bypass path. Storage is not
// reset; the output is forced to zero while empty so stale data never leaks.
module capture_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          not_empty,
  output logic [AW:0]   level
);

  localparam int LVL_W = AW + 1;
  localparam logic [AW:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  // Qualify requests: pop needs data, push needs room unless a pop frees a slot.
  always_comb begin
    pop_ok    = pop && (level != '0);
    push_ok   = push && ((level != FULL_LVL) || pop_ok);
    not_empty = (level != '0);
    dout      = not_empty ? mem[rd_ptr] : '0;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Entry storage; a full FIFO with a simultaneous pop overwrites the slot
  // being read out this same cycle, which is safe because the read is
  // combinational and completes before the edge.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sum_capture.sv
// Adder result checker with capture FIFO. While running, each valid upstream
// sample is checked against a full-width reference sum and, if there is room,
// stored as {sum, mismatch}. A mismatch can optionally halt capture until the
// next start. Event counters track accepted, dropped and erroneous samples.
module sum_capture
  import sum_capture_pkg::*;
#(
  parameter int W           = 8,
  parameter int DEPTH       = 8,
  parameter int HALT_ON_ERR = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_sum,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W:0]       out_sum,
  output logic             out_err,
  output logic [AW:0]      level,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int LVL_W = AW + 1;
  localparam logic [AW:0] FULL_LVL = LVL_W'(DEPTH);

  logic [1:0]   state_q;
  logic [1:0]   state_d;
  logic [W:0]   ref_sum;
  logic         mismatch;
  logic         offer;
  logic         accept;
  logic         pop;
  logic [W+1:0] fifo_din;
  logic [W+1:0] fifo_dout;

  // Saturating increment used by the drop and error counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Reference sum at W+1 bits so the carry out is never lost, plus the
  // offer/accept decision for the current sample.
  always_comb begin
    ref_sum  = {1'b0, in_a} + {1'b0, in_b};
    mismatch = (in_sum != ref_sum);
    offer    = (state_q == ST_RUN) && in_valid;
    pop      = out_valid && out_ready;
    accept   = offer && ((level != FULL_LVL) || pop);
    fifo_din = {in_sum, mismatch};
  end

  capture_fifo #(
    .DW    (W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .pop       (pop),
    .din       (fifo_din),
    .dout      (fifo_dout),
    .not_empty (out_valid),
    .level     (level)
  );

  assign out_sum = fifo_dout[W+1:1];
  assign out_err = fifo_dout[0];
  assign state   = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; stop takes priority over start and over halting, and
  // the unused encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (stop)       state_d = ST_IDLE;
        else if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop)
          state_d = ST_IDLE;
        else if ((HALT_ON_ERR != 0) && accept && mismatch)
          state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (stop)       state_d = ST_IDLE;
        else if (start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Event counters: accepted samples wrap, drops and errors saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      drop_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      if (accept)            sample_cnt <= sample_cnt + CNT_W'(1);
      if (offer && !accept)  drop_cnt   <= sat_inc(drop_cnt);
      if (accept && mismatch) err_cnt   <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_sum_capture.sv
// Directed bench for sum_capture with hand-computed expectations.
module tb_sum_capture;

  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [8:0]  in_sum;
  logic        out_ready;
  logic        out_valid;
  logic [8:0]  out_sum;
  logic        out_err;
  logic [3:0]  level;
  logic [1:0]  state;
  logic [15:0] sample_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sum_capture #(
    .W           (W),
    .DEPTH       (DEPTH),
    .HALT_ON_ERR (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .in_valid   (in_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sum     (in_sum),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_sum    (out_sum),
    .out_err    (out_err),
    .level      (level),
    .state      (state),
    .sample_cnt (sample_cnt),
    .drop_cnt   (drop_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, input int s);
    in_valid = 1'b1;
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_sum   = 9'(s);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int exp_sums [3] = '{3, 510, 15};
  int drain_exp [8] = '{3, 5, 7, 9, 11, 13, 15, 127};

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_sum = '0; out_ready = 1'b0;
    #1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_state",   32'(state), 0);
    chk("rst_level",   32'(level), 0);
    chk("rst_valid",   32'(out_valid), 0);
    chk("rst_sum",     32'(out_sum), 0);
    chk("rst_err",     32'(out_err), 0);
    chk("rst_samples", 32'(sample_cnt), 0);
    chk("rst_drops",   32'(drop_cnt), 0);
    chk("rst_errs",    32'(err_cnt), 0);

    // In-order capture with consumer always ready, including carry-out sum
    pulse_start();
    chk("run_state", 32'(state), 1);
    out_ready = 1'b1;
    drive(1, 2, 3);
    step();
    chk("basic_valid0", 32'(out_valid), 1);
    chk("basic_sum0",   32'(out_sum), 32'(exp_sums[0]));
    chk("basic_err0",   32'(out_err), 0);
    drive(255, 255, 510);
    step();
    chk("basic_sum1", 32'(out_sum), 32'(exp_sums[1]));
    chk("basic_err1", 32'(out_err), 0);
    drive(7, 8, 15);
    step();
    chk("basic_sum2", 32'(out_sum), 32'(exp_sums[2]));
    chk("basic_err2", 32'(out_err), 0);
    in_valid = 1'b0;
    step();
    chk("basic_samples", 32'(sample_cnt), 3);
    chk("basic_empty",   32'(out_valid), 0);
    chk("basic_level",   32'(level), 0);

    // Overflow: 10 samples into an 8-entry FIFO with consumer stalled
    rst = 1'b1;
    step();
    rst = 1'b0;
    pulse_start();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(i, i + 1, 2 * i + 1);
      step();
    end
    in_valid = 1'b0;
    chk("ovf_level",   32'(level), 8);
    chk("ovf_drops",   32'(drop_cnt), 2);
    chk("ovf_samples", 32'(sample_cnt), 8);
    chk("ovf_errs",    32'(err_cnt), 0);

    // Full FIFO with simultaneous push and pop
    chk("full_head", 32'(out_sum), 1);
    drive(100, 27, 127);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("fullpp_level",   32'(level), 8);
    chk("fullpp_drops",   32'(drop_cnt), 2);
    chk("fullpp_samples", 32'(sample_cnt), 9);

    // Drain and confirm order
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_sum%0d", k), 32'(out_sum), 32'(drain_exp[k]));
      step();
    end
    out_ready = 1'b0;
    chk("drain_level", 32'(level), 0);
    chk("drain_valid", 32'(out_valid), 0);

    // Mismatch halts capture; following sample ignored; start resumes
    drive(4, 5, 10);
    step();
    chk("halt_state",   32'(state), 2);
    chk("halt_errcnt",  32'(err_cnt), 1);
    chk("halt_outerr",  32'(out_err), 1);
    chk("halt_outsum",  32'(out_sum), 10);
    chk("halt_samples", 32'(sample_cnt), 10);
    drive(1, 1, 2);
    step();
    in_valid = 1'b0;
    chk("halt_ign_level",   32'(level), 1);
    chk("halt_ign_samples", 32'(sample_cnt), 10);
    chk("halt_ign_drops",   32'(drop_cnt), 2);
    pulse_start();
    chk("resume_state", 32'(state), 1);

    // Full-width compare: truncated sum must be flagged
    out_ready = 1'b1;
    drive(200, 100, 300);
    step();
    chk("wide_ok_sum",   32'(out_sum), 300);
    chk("wide_ok_err",   32'(out_err), 0);
    chk("wide_ok_state", 32'(state), 1);
    drive(200, 100, 44);
    step();
    in_valid = 1'b0;
    chk("trunc_sum",    32'(out_sum), 44);
    chk("trunc_err",    32'(out_err), 1);
    chk("trunc_state",  32'(state), 2);
    chk("trunc_errcnt", 32'(err_cnt), 2);
    step();
    chk("halt_drain", 32'(out_valid), 0);

    // Stop from HALTED, then start+stop collisions
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("halted_stop", 32'(state), 0);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("idle_both", 32'(state), 0);
    pulse_start();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("run_both", 32'(state), 0);

    // Samples in IDLE are ignored
    drive(3, 3, 6);
    step();
    in_valid = 1'b0;
    chk("idle_ign_samples", 32'(sample_cnt), 12);
    chk("idle_ign_level",   32'(level), 0);

    // Reset mid-operation with queued entries, overriding start
    pulse_start();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(i, 1, i + 1);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_level",   32'(level), 5);
    chk("pre_rst_samples", 32'(sample_cnt), 17);
    rst = 1'b1; start = 1'b1; out_ready = 1'b1;
    drive(9, 9, 18);
    step();
    rst = 1'b0; start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("mrst_valid",   32'(out_valid), 0);
    chk("mrst_level",   32'(level), 0);
    chk("mrst_state",   32'(state), 0);
    chk("mrst_sum",     32'(out_sum), 0);
    chk("mrst_samples", 32'(sample_cnt), 0);
    chk("mrst_drops",   32'(drop_cnt), 0);
    chk("mrst_errs",    32'(err_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_capture.md
SUM_CAPTURE -- requirements
Module: sum_capture

Interface
REQ-001 Parameter W, default 8, operand width of the upstream adder (sum is W+1 bits).
REQ-002 Parameter DEPTH, default 8, capture FIFO depth in entries (power of two, >=2).
REQ-003 Parameter HALT_ON_ERR, default 1, enables the halt-on-mismatch transition.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  single-cycle pulse, begin/resume capture.
REQ-007 stop  input  1  single-cycle pulse, end capture.
REQ-008 in_valid  input  1  upstream sample present this cycle.
REQ-009 in_a  input  W  adder operand a.
REQ-010 in_b  input  W  adder operand b.
REQ-011 in_sum  input  W+1  adder result under check.
REQ-012 out_ready  input  1  consumer accepts head entry.
REQ-013 out_valid  output  1  FIFO non-empty; head entry presented.
REQ-014 out_sum  output  W+1  head entry sum.
REQ-015 out_err  output  1  head entry mismatch flag.
REQ-016 level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-017 state  output  2  FSM state encoding.
REQ-018 sample_cnt, drop_cnt, err_cnt  output  16 each  event counters.

Function
REQ-019 FSM states: IDLE=0, RUN=1, HALTED=2; encoding 3 unused and SHALL recover to IDLE next cycle.
REQ-020 Transitions: IDLE->RUN on start; RUN->IDLE on stop; RUN->HALTED on accepted sample with mismatch when HALT_ON_ERR=1; HALTED->RUN on start; HALTED->IDLE on stop.
REQ-021 start and stop in the same cycle: stop wins.
REQ-022 Mismatch = (in_sum != zero-extended in_a + in_b computed at W+1 bits); no truncation.
REQ-023 Sample offered only when state==RUN and in_valid; in IDLE/HALTED, in_valid is ignored and no counter moves.
REQ-024 Offered sample accepted when level<DEPTH, or level==DEPTH with pop in the same cycle; accepted entry stores {in_sum, mismatch}.
REQ-025 Offered sample not accepted: discarded, drop_cnt +1, err_cnt unaffected.
REQ-026 Pop = out_valid && out_ready; pop on empty has no effect.
REQ-027 Push-to-out_valid latency 1 cycle; no same-cycle bypass when empty.
REQ-028 FIFO is first-word-fall-through; order preserved; pointers wrap modulo DEPTH.
REQ-029 Simultaneous push and pop: level unchanged.
REQ-030 sample_cnt +1 per accepted sample, wraps at 2^16.
REQ-031 drop_cnt and err_cnt +1 per event, saturate at 0xFFFF.
REQ-032 The sample causing RUN->HALTED is itself accepted and counted; subsequent samples are ignored.
REQ-033 FIFO drains normally in every state.

Reset
REQ-034 rst high at a clk edge: state=IDLE, level=0, out_valid=0, out_sum=0, out_err=0, all counters=0.
REQ-035 rst mid-operation discards all FIFO contents and overrides start, stop, push and pop in that cycle.

Structure
REQ-036 Package sum_capture_pkg holds state encodings and counter width constant (16).
REQ-037 FIFO storage, pointers and level live in sub-module capture_fifo (parameters W+2, DEPTH); FSM, checker and counters live in sum_capture.

Verification
REQ-038 start; 3 samples (1,2,3),(255,255,510),(7,8,15), out_ready=1 -> out_sum 3,510,15 in order, out_err=0, sample_cnt=3.
REQ-039 RUN, out_ready=0, 10 consecutive valid samples, DEPTH=8 -> level=8, drop_cnt=2, sample_cnt=8.
REQ-040 RUN, sample (4,5,sum=10) with HALT_ON_ERR=1 -> entry out_err=1, err_cnt=1, state=HALTED; next valid sample ignored; start -> RUN.
REQ-041 level=8, in_valid and out_ready both high -> accepted, level stays 8, drop_cnt unchanged.
REQ-042 start and stop asserted together from IDLE -> state stays IDLE; from RUN -> IDLE.
REQ-043 rst after 5 entries queued and counters nonzero -> next cycle out_valid=0, level=0, state=IDLE, counters 0.
